// File: rtl/mdc_fft_ctrl.sv
// Control sequencer for a radix-2 multi-path delay commutator FFT: tracks the beat
// counter, per-stage validity, commutator selects, twiddle addresses and frame completion.
module mdc_fft_ctrl #(
  parameter int LOG2N = 5
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start_i,
  input  logic                               cont_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  output logic                               busy_o,
  output logic [LOG2N-2:0]                   com_sel_o,
  output logic [(LOG2N-1)*(LOG2N-1)-1:0]     tw_addr_o,
  output logic [LOG2N-2:0]                   stage_act_o,
  output logic                               out_valid_o,
  output logic                               frame_done_o
);

  localparam int S    = LOG2N - 1;
  localparam int HALF = 1 << S;
  localparam int GW   = LOG2N;

  localparam logic [GW-1:0] G_ONE    = GW'(1);
  localparam logic [GW-1:0] G_HALF   = GW'(HALF);
  localparam logic [GW-1:0] F_LAST   = GW'(HALF - 1);
  localparam logic [GW-1:0] G_END    = GW'(2 * HALF - 2);
  localparam logic [S-1:0]  P_LAST   = S'(HALF - 1);
  localparam logic [S-1:0]  P_ONE    = S'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    g_q, g_d, g_inc;
  logic [S-1:0]     act_q, act_d;
  logic [S-1:0]     set_s, clr_s;
  logic [S-1:0]     com_q, com_nxt;
  logic [S*S-1:0]   tw_q, tw_nxt;
  logic             in_ready_q, busy_q, fd_q, fd_d;
  logic             adv;
  logic [S-1:0]     k_last_now;

  assign g_inc      = g_q + G_ONE;
  // Last stage has D=1, so its local index is simply p+1.
  assign k_last_now = g_q[S-1:0] + P_ONE;

  // Per-stage decode: k_s = (p - F_s) mod N/2 reduces to p + D_s since F_s = N/2 - D_s.
  for (genvar s = 1; s <= S; s++) begin : g_stage
    localparam int            D     = 1 << (S - s);
    localparam logic [GW-1:0] F_S   = GW'(HALF - D);
    localparam logic [GW-1:0] F_END = GW'(HALF - D + HALF - 1);
    localparam logic [S-1:0]  D_S   = S'(D);
    localparam logic [S-1:0]  MASK  = S'(2 * D - 1);
    logic [S-1:0] k_nxt;
    logic [S-1:0] k_mod;

    assign k_nxt = g_d[S-1:0] + D_S;
    assign k_mod = k_nxt & MASK;
    assign set_s[s-1] = (g_d == F_S);
    assign clr_s[s-1] = (g_q == F_END);
    assign com_nxt[s-1] = act_d[s-1] & k_nxt[S-s];
    assign tw_nxt[(s-1)*S +: S] = act_d[s-1] ? S'(k_mod << (s - 1)) : {S{1'b0}};
  end

  // Beat advance and state/counter next-state.
  always_comb begin
    adv     = 1'b0;
    state_d = state_q;
    g_d     = g_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = FILL;
          g_d     = '0;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        adv = in_valid_i;
        if (in_valid_i) begin
          g_d = g_inc;
          if (g_inc == F_LAST) begin
            state_d = RUN;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end
      RUN: begin
        adv = in_valid_i;
        if (in_valid_i && (g_q[S-1:0] == P_LAST)) begin
          if (cont_i) begin
            g_d = '0;
          end else begin
            state_d = DRAIN;
            g_d     = G_HALF;
          end
        end else if (in_valid_i) begin
          g_d = g_inc;
        end else begin
          g_d = g_q;
        end
      end
      DRAIN: begin
        adv = 1'b1;
        if (g_q == G_END) begin
          state_d = IDLE;
          g_d     = '0;
        end else begin
          g_d = g_inc;
        end
      end
      default: begin
        state_d = IDLE;
        g_d     = '0;
      end
    endcase
  end

  // Stage validity tracking and frame completion detect.
  always_comb begin
    act_d = act_q;
    fd_d  = adv & act_q[S-1] & (k_last_now == P_LAST);
    if (adv && ((state_q == FILL) || (state_q == RUN))) begin
      act_d = act_q | set_s;
    end else if (adv && (state_q == DRAIN)) begin
      act_d = act_q & ~clr_s;
    end else begin
      act_d = act_q;
    end
  end

  // State and registered outputs, decoded from next-state so every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      g_q        <= '0;
      act_q      <= '0;
      com_q      <= '0;
      tw_q       <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      act_q      <= act_d;
      com_q      <= com_nxt;
      tw_q       <= tw_nxt;
      in_ready_q <= (state_d == FILL) || (state_d == RUN);
      busy_q     <= (state_d != IDLE);
      fd_q       <= fd_d;
    end
  end

  assign in_ready_o   = in_ready_q;
  assign busy_o       = busy_q;
  assign com_sel_o    = com_q;
  assign tw_addr_o    = tw_q;
  assign stage_act_o  = act_q;
  assign out_valid_o  = act_q[S-1];
  assign frame_done_o = fd_q;

endmodule

// File: tb/tb_mdc_fft_ctrl.sv
// Self-checking bench: a global-beat-index model predicts every output each cycle
// for an N=32 and an N=16 instance, plus literal spot checks.
module tb_mdc_fft_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start_a = 1'b0, cont_a = 1'b0, valid_a = 1'b0;
  logic start_b = 1'b0, cont_b = 1'b0, valid_b = 1'b0;

  logic        ready_a, busy_a, ov_a, fd_a;
  logic [3:0]  cs_a, sa_a;
  logic [15:0] tw_a;
  logic        ready_b, busy_b, ov_b, fd_b;
  logic [2:0]  cs_b, sa_b;
  logic [8:0]  tw_b;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int fd_cnt_a = 0, fd_t1 = 0, fd_t2 = 0, ov_cnt_a = 0, ov_cnt_b = 0;

  always #5 clk = ~clk;

  mdc_fft_ctrl #(.LOG2N(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .cont_i(cont_a), .in_valid_i(valid_a),
    .in_ready_o(ready_a), .busy_o(busy_a), .com_sel_o(cs_a), .tw_addr_o(tw_a),
    .stage_act_o(sa_a), .out_valid_o(ov_a), .frame_done_o(fd_a)
  );

  mdc_fft_ctrl #(.LOG2N(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .cont_i(cont_b), .in_valid_i(valid_b),
    .in_ready_o(ready_b), .busy_o(busy_b), .com_sel_o(cs_b), .tw_addr_o(tw_b),
    .stage_act_o(sa_b), .out_valid_o(ov_b), .frame_done_o(fd_b)
  );

  // Model: t counts every advance since start; inputs occupy t < ends, then N/2-1 drain beats.
  typedef struct {
    bit busy;
    int t;
    int ends;
    bit fd;
  } m_t;

  m_t ma = '{1'b0, 0, 0, 1'b0};
  m_t mb = '{1'b0, 0, 0, 1'b0};

  function automatic m_t m_step(input m_t m, input int lg, input logic st, input logic ct,
                                input logic vl);
    m_t r;
    int half, fs;
    bit adv;
    r = m;
    r.fd = 1'b0;
    half = 1 << (lg - 1);
    fs = half - 1;
    if (!m.busy) begin
      if (st) begin
        r.busy = 1'b1;
        r.t = 0;
        r.ends = half;
      end
    end else begin
      adv = (m.t < m.ends) ? vl : 1'b1;
      if (adv) begin
        if (m.t >= fs && ((m.t - fs) % half) == half - 1) r.fd = 1'b1;
        if (m.t == m.ends - 1 && ct) r.ends = m.ends + half;
        r.t = m.t + 1;
        if (r.t == r.ends + fs) begin
          r.busy = 1'b0;
          r.t = 0;
        end
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '{1'b0, 0, 0, 1'b0};
      mb <= '{1'b0, 0, 0, 1'b0};
    end else begin
      ma <= m_step(ma, 5, start_a, cont_a, valid_a);
      mb <= m_step(mb, 4, start_b, cont_b, valid_b);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_inst(input string tag, input m_t m, input int lg, input logic [3:0] cs,
                            input logic [15:0] tw, input logic [3:0] sa, input logic rd,
                            input logic bs, input logic ov, input logic fd);
    int ss, half, d, f, k;
    logic [3:0]  ecs, esa;
    logic [15:0] etw, fld;
    ss = lg - 1;
    half = 1 << ss;
    ecs = '0;
    esa = '0;
    etw = '0;
    for (int s = 1; s <= ss; s++) begin
      d = 1 << (ss - s);
      f = half - d;
      if (m.busy && m.t >= f && m.t <= f + m.ends - 1) begin
        k = (m.t - f) % half;
        esa[s-1] = 1'b1;
        ecs[s-1] = ((k >> (ss - s)) & 1) != 0;
        fld = 16'(((k % (2 * d)) << (s - 1)) & (half - 1));
        etw = etw | (fld << ((s - 1) * ss));
      end
    end
    chk({tag, ".busy"}, 32'(bs), 32'(m.busy));
    chk({tag, ".in_ready"}, 32'(rd), 32'(m.busy && (m.t < m.ends)));
    chk({tag, ".stage_act"}, 32'(sa), 32'(esa));
    chk({tag, ".com_sel"}, 32'(cs), 32'(ecs));
    chk({tag, ".tw_addr"}, 32'(tw), 32'(etw));
    chk({tag, ".out_valid"}, 32'(ov), 32'(esa[ss-1]));
    chk({tag, ".frame_done"}, 32'(fd), 32'(m.fd));
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (fd_a) begin
      fd_cnt_a++;
      if (fd_cnt_a == 1) fd_t1 = cyc;
      if (fd_cnt_a == 2) fd_t2 = cyc;
    end
    if (ov_a) ov_cnt_a++;
    if (ov_b) ov_cnt_b++;
    check_inst("A", ma, 5, cs_a, tw_a, sa_a, ready_a, busy_a, ov_a, fd_a);
    check_inst("B", mb, 4, {1'b0, cs_b}, {7'b0, tw_b}, {1'b0, sa_b}, ready_b, busy_b, ov_b, fd_b);
  endtask

  task automatic wait_t(input bit use_b, input int target);
    int n;
    n = 0;
    while (!((use_b ? mb.busy : ma.busy) && (use_b ? mb.t : ma.t) == target) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      fails++;
      $display("FAIL wait_t: beat %0d never reached (got n=%0d required <200)", target, n);
    end
  endtask

  task automatic wait_idle(input bit use_b);
    int n;
    n = 0;
    while ((use_b ? mb.busy : ma.busy) && n < 200) begin
      tick();
      n++;
    end
    tick();
    if (n >= 200) begin
      checks++;
      fails++;
      $display("FAIL wait_idle: frame never ended (got n=%0d required <200)", n);
    end
  endtask

  task automatic randomize_inputs();
    start_a = 1'($urandom_range(0, 1));
    cont_a  = 1'($urandom_range(0, 1));
    valid_a = 1'($urandom_range(0, 1));
    start_b = 1'($urandom_range(0, 1));
    cont_b  = 1'($urandom_range(0, 1));
    valid_b = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_inputs();
    start_a = 1'b0; cont_a = 1'b0; valid_a = 1'b0;
    start_b = 1'b0; cont_b = 1'b0; valid_b = 1'b0;
  endtask

  task automatic run_single_a(input bit stall);
    cont_a = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    valid_a = 1'b1;
    fd_cnt_a = 0;
    ov_cnt_a = 0;
    wait_t(1'b0, 8);
    chk("p.cs0@8", 32'(cs_a[0]), 32'd0);
    chk("p.tw0@8", 32'(tw_a[3:0]), 32'd0);
    if (stall) begin
      wait_t(1'b0, 10);
      valid_a = 1'b0;
      repeat (3) begin
        tick();
        chk("p.stall_tw0", 32'(tw_a[3:0]), 32'd2);
        chk("p.stall_cs0", 32'(cs_a[0]), 32'd0);
      end
      valid_a = 1'b1;
    end
    wait_t(1'b0, 15);
    chk("p.ov@15", 32'(ov_a), 32'd1);
    chk("p.cs3@15", 32'(cs_a[3]), 32'd0);
    tick();
    chk("p.cs3@16", 32'(cs_a[3]), 32'd1);
    chk("p.cs0@16", 32'(cs_a[0]), 32'd1);
    chk("p.tw0@16", 32'(tw_a[3:0]), 32'd8);
    wait_t(1'b0, 23);
    chk("p.tw0@23", 32'(tw_a[3:0]), 32'd15);
    wait_idle(1'b0);
    chk("p.fd_count", 32'(fd_cnt_a), 32'd1);
    chk("p.ov_count", 32'(ov_cnt_a), 32'd16);
    chk("p.busy_end", 32'(busy_a), 32'd0);
    valid_a = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (4) begin
      randomize_inputs();
      tick();
    end
    clear_inputs();
    #2 rst_n = 1'b1;
    repeat (3) tick();
    chk("rst.busy_a", 32'(busy_a), 32'd0);
    chk("rst.tw_a", 32'(tw_a), 32'd0);

    // single frame, then with a stall at beat 10
    run_single_a(1'b0);
    run_single_a(1'b1);

    // continuous: two frames back to back
    cont_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    valid_a = 1'b1;
    fd_cnt_a = 0;
    wait_t(1'b0, 16);
    cont_a = 1'b0;
    chk("c.ready@16", 32'(ready_a), 32'd1);
    chk("c.cs0@16", 32'(cs_a[0]), 32'd1);
    chk("c.tw0@16", 32'(tw_a[3:0]), 32'd8);
    wait_t(1'b0, 24);
    chk("c.cs0@24", 32'(cs_a[0]), 32'd0);
    chk("c.tw0@24", 32'(tw_a[3:0]), 32'd0);
    wait_idle(1'b0);
    chk("c.fd_count", 32'(fd_cnt_a), 32'd2);
    chk("c.fd_gap", 32'(fd_t2 - fd_t1), 32'd16);
    valid_a = 1'b0;

    // reset in the middle of a continuous run
    cont_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    valid_a = 1'b1;
    wait_t(1'b0, 20);
    #2 rst_n = 1'b0;
    randomize_inputs();
    tick();
    chk("r.busy", 32'(busy_a), 32'd0);
    chk("r.ready", 32'(ready_a), 32'd0);
    chk("r.stage_act", 32'(sa_a), 32'd0);
    chk("r.com_sel", 32'(cs_a), 32'd0);
    chk("r.tw", 32'(tw_a), 32'd0);
    randomize_inputs();
    tick();
    clear_inputs();
    #2 rst_n = 1'b1;
    repeat (2) tick();
    chk("r.idle_busy", 32'(busy_a), 32'd0);
    run_single_a(1'b0);

    // N=16 instance
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    valid_b = 1'b1;
    ov_cnt_b = 0;
    wait_t(1'b1, 6);
    chk("b.ov@6", 32'(ov_b), 32'd0);
    tick();
    chk("b.ov@7", 32'(ov_b), 32'd1);
    chk("b.tw2@7", 32'(tw_b[8:6]), 32'd0);
    tick();
    chk("b.tw2@8", 32'(tw_b[8:6]), 32'd4);
    tick();
    chk("b.tw2@9", 32'(tw_b[8:6]), 32'd0);
    wait_idle(1'b1);
    chk("b.ov_count", 32'(ov_cnt_b), 32'd8);
    valid_b = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/mdc_fft_ctrl.md
MDC_FFT_CTRL -- requirements
Module: mdc_fft_ctrl

Interface
REQ-001 SHALL have parameter LOG2N, default 5, FFT size N=2^LOG2N with legal range 3..10; S=LOG2N-1 stages, numbered s=1..S.
REQ-002 SHALL have clk, input, 1, clock; all state changes on the rising edge.
REQ-003 SHALL have rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have start, input, 1, frame start request, honoured only in IDLE.
REQ-005 SHALL have cont, input, 1, continuous mode, sampled on the last input beat of each frame.
REQ-006 SHALL have in_valid, input, 1, one sample-pair beat offered this cycle.
REQ-007 SHALL have in_ready, output, 1, beat acceptance enable, high in FILL and RUN only.
REQ-008 SHALL have busy, output, 1, high whenever the state is not IDLE.
REQ-009 SHALL have com_sel, output, S, commutator select; bit s-1 drives stage s.
REQ-010 SHALL have tw_addr, output, S*S, twiddle ROM address; field s-1 = [(s-1)*S +: S].
REQ-011 SHALL have stage_act, output, S, stage s holds valid data.
REQ-012 SHALL have out_valid, output, 1, equal to stage_act[S].
REQ-013 SHALL have frame_done, output, 1, one-cycle pulse per completed frame.

Function
REQ-014 SHALL define D_s=2^(S-s) and F_s=D_1+...+D_s; F_S=N/2-1; for N=32, F=(8,12,14,15).
REQ-015 SHALL implement FSM states IDLE, FILL, RUN, DRAIN; "adv" = (in_valid & in_ready) in FILL/RUN, and adv=1 every cycle in DRAIN.
REQ-016 SHALL keep beat counter g (LOG2N bits); g increments on adv, holds otherwise; p = g[S-1:0].
REQ-017 SHALL move IDLE->FILL on start with g=0; no beat is accepted in the start cycle.
REQ-018 SHALL move FILL->RUN on the adv that brings g to F_S.
REQ-019 On the adv at p=N/2-1 in RUN, SHALL do the following: if cont=1, stay in RUN with g wrapping to 0; else go to DRAIN with g=N/2.
REQ-020 SHALL set stage_act[s] on the adv that brings g to F_s.
REQ-021 In DRAIN, SHALL clear stage_act[s] on the adv at g=F_s+N/2-1.
REQ-022 SHALL move DRAIN->IDLE when stage_act[S] clears; DRAIN lasts N/2-1 cycles.
REQ-023 SHALL define stage s local index k_s=(p-F_s) mod N/2, S bits wide.
REQ-024 SHALL drive com_sel[s-1] = stage_act[s] & k_s[S-s]; the select toggles every D_s beats.
REQ-025 SHALL drive tw_addr field s-1 = stage_act[s] ? (k_s mod 2D_s)<<(s-1) : 0, truncated to S bits.
REQ-026 SHALL pulse frame_done in the cycle after an adv where stage_act[S]=1 and k_S=N/2-1.
REQ-027 SHALL decode all outputs from registered state only, with no input-to-output combinational path; outputs in the cycle g=k apply to beat k.
REQ-028 When adv=0, g, stage_act, com_sel, tw_addr and the state SHALL hold.
REQ-029 SHALL ignore start outside IDLE and in_valid in IDLE/DRAIN.
REQ-030 SHALL drop a start that coincides with the IDLE-entry cycle; start is honoured only while the state is IDLE.

Reset
REQ-031 On rst_n low, SHALL immediately force state=IDLE, g=0, stage_act=0, com_sel=0, tw_addr=0, in_ready=0, busy=0, out_valid=0, frame_done=0, regardless of operation in progress.
REQ-032 After rst_n rises, SHALL require a new start; no partial frame resumes.

Verification
REQ-033 Reset: with rst_n low and random inputs -> all outputs 0; after release and no start -> outputs remain 0.
REQ-034 Single frame, N=32, cont=0, 16 contiguous beats:
- com_sel[0]=0 on beats 8..15 and 1 on beats 16..23.
- tw_addr field 0 steps 0..15 over g=8..23.
- com_sel[3] toggles every beat from g=15.
- out_valid high for g=15..30; frame_done pulses once.
- Then IDLE with busy=0.
REQ-035 Stall: in_valid low for 3 cycles at g=10 -> g, com_sel and tw_addr frozen; the sequence resumes unchanged.
REQ-036 Continuous: cont=1, 32 contiguous beats -> no DRAIN between frames; g wraps 15->0; com_sel[0] period 16 is unbroken; frame_done pulses twice; the second follows 16 cycles after the first.
REQ-037 Reset mid-RUN at g=20 -> all outputs 0 next edge; a new start restarts from g=0 with the REQ-034 sequence.
REQ-038 LOG2N=4 -> F=(4,6,7); out_valid high for g=7..14; tw_addr field 2 = 0,4 alternating.
